// File: rtl/window_generator.sv
// window_generator: streaming KxK sliding-window stage built from K-1 line buffers.
// Each window is emitted one cycle after its bottom-right pixel is accepted.
module window_generator #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] window [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
    output logic                  frame_done
);
    localparam int K  = KERNEL_SIZE;
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

    if (IMG_WIDTH < KERNEL_SIZE) begin : g_bad_width
        $error("window_generator: IMG_WIDTH must be >= KERNEL_SIZE");
    end
    if (IMG_HEIGHT < KERNEL_SIZE) begin : g_bad_height
        $error("window_generator: IMG_HEIGHT must be >= KERNEL_SIZE");
    end

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  out_valid_q, out_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic                  accept, col_last, row_last, win_emit;
    logic [DATA_WIDTH-1:0] win_q [0:K-1][0:K-1];
    logic [DATA_WIDTH-1:0] lb_q  [0:K-2][0:IMG_WIDTH-1];

    assign in_ready   = !out_valid_q || out_ready;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign window     = win_q;

    always_comb begin
        accept       = in_valid && in_ready;
        col_last     = col_q == COL_LAST;
        row_last     = row_q == ROW_LAST;
        col_d        = accept ? (col_last ? '0 : col_q + 1'b1) : col_q;
        row_d        = (accept && col_last) ? (row_last ? '0 : row_q + 1'b1) : row_q;
        // Columns left of K-1 would mix the previous row's tail into the window.
        win_emit     = accept && row_q >= ROW_MIN && col_q >= COL_MIN;
        out_valid_d  = accept ? win_emit : (out_valid_q && !out_ready);
        frame_done_d = accept && col_last && row_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    win_q[i][j] <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            if (accept) begin
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K - 1; j++)
                        win_q[i][j] <= win_q[i][j+1];
                for (int i = 0; i < K - 1; i++)
                    win_q[i][K-1] <= lb_q[i][col_q];
                win_q[K-1][K-1] <= pixel_in;
            end
        end
    end

    // Line buffers are plain storage: oldest row in lb_q[0], newest in lb_q[K-2].
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < K - 2; i++)
                lb_q[i][col_q] <= lb_q[i+1][col_q];
            lb_q[K-2][col_q] <= pixel_in;
        end
    end
endmodule

// File: tb/tb_window_generator.sv
// tb_window_generator: directed and randomised handshake checks of window_generator.
module tb_window_generator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic       rst3, iv3, ir3, ov3, or3, fd3;
    logic [7:0] px3;
    logic [7:0] win3 [0:2][0:2];
    logic [127:0] p3;

    logic       rs, ivs, ir2, ov2, fd2, ir4, ov4, fd4;
    logic [7:0] pxs;
    logic [7:0] win2 [0:1][0:1];
    logic [7:0] win4 [0:3][0:3];
    logic [127:0] p2, p4;

    window_generator #(.DATA_WIDTH(8), .KERNEL_SIZE(3), .IMG_WIDTH(5), .IMG_HEIGHT(5)) u3 (
        .clk(clk), .reset(rst3), .in_valid(iv3), .in_ready(ir3), .pixel_in(px3),
        .out_valid(ov3), .out_ready(or3), .window(win3), .frame_done(fd3));

    window_generator #(.DATA_WIDTH(8), .KERNEL_SIZE(2), .IMG_WIDTH(4), .IMG_HEIGHT(3)) u2 (
        .clk(clk), .reset(rs), .in_valid(ivs), .in_ready(ir2), .pixel_in(pxs),
        .out_valid(ov2), .out_ready(1'b1), .window(win2), .frame_done(fd2));

    window_generator #(.DATA_WIDTH(8), .KERNEL_SIZE(4), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u4 (
        .clk(clk), .reset(rs), .in_valid(ivs), .in_ready(ir4), .pixel_in(pxs),
        .out_valid(ov4), .out_ready(1'b1), .window(win4), .frame_done(fd4));

    // Windows are flattened row-major with [0][0] in the most significant byte used.
    always_comb begin
        p3 = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p3 = (p3 << 8) | 128'(win3[i][j]);
    end
    always_comb begin
        p2 = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                p2 = (p2 << 8) | 128'(win2[i][j]);
    end
    always_comb begin
        p4 = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                p4 = (p4 << 8) | 128'(win4[i][j]);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // n-th window of a frame whose pixel at (r,c) is r*w+c+1.
    function automatic logic [127:0] exp_win(input int k, input int w, input int n);
        int nc, rr, cc;
        nc = w - k + 1;
        rr = k - 1 + n / nc;
        cc = k - 1 + n % nc;
        exp_win = '0;
        for (int i = 0; i < k; i++)
            for (int j = 0; j < k; j++)
                exp_win = (exp_win << 8) | 128'((rr - k + 1 + i) * w + (cc - k + 1 + j) + 1);
    endfunction

    int pr, pc, n3, acc_n, win_cnt, fd_cnt;
    logic eov, efd, s_ov, s_ir;
    logic [127:0] s_win, snap;

    task automatic cyc3(input logic v, input logic r);
        logic acc, cons;
        iv3 = v;
        or3 = r;
        px3 = 8'(pr * 5 + pc + 1);
        acc = v && (!eov || r);
        cons = eov && r;
        @(negedge clk);
        s_ov = ov3;
        s_ir = ir3;
        s_win = p3;
        check("in_ready", ir3, !eov || r);
        check("out_valid", ov3, eov);
        check("frame_done", fd3, efd);
        if (ov3 && r) begin
            check("window", p3, exp_win(3, 5, n3));
            n3 = (n3 == 8) ? 0 : n3 + 1;
            win_cnt++;
        end
        if (fd3) fd_cnt++;
        @(posedge clk);
        #1;
        efd = acc && pr == 4 && pc == 4;
        if (acc) eov = pr >= 2 && pc >= 2;
        else if (cons) eov = 1'b0;
        if (acc) begin
            acc_n++;
            if (pc == 4) begin
                pc = 0;
                pr = (pr == 4) ? 0 : pr + 1;
            end else pc++;
        end
    endtask

    task automatic do_reset(input int n);
        rst3 = 1'b1;
        iv3 = 1'b1;
        or3 = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst3 = 1'b0;
        iv3 = 1'b0;
        pr = 0; pc = 0; n3 = 0; acc_n = 0; win_cnt = 0; fd_cnt = 0;
        eov = 1'b0; efd = 1'b0;
        @(negedge clk);
        check("rst_out_valid", ov3, 1'b0);
        check("rst_frame_done", fd3, 1'b0);
        check("rst_window", p3, 128'd0);
        check("rst_in_ready", ir3, 1'b1);
        @(posedge clk);
        #1;
    endtask

    int n2, n4, f2, f4, rnd;

    initial begin
        rnd = $urandom(32'd7);
        rst3 = 1'b1; iv3 = 1'b0; or3 = 1'b1; px3 = '0;
        rs = 1'b1; ivs = 1'b0; pxs = '0;
        @(posedge clk);
        #1;
        do_reset(2);
        for (int t = 0; t < 100 && win_cnt < 9; t++) cyc3(1'b1, 1'b1);
        check("s1_windows", 128'(win_cnt), 128'd9);
        check("s1_frame_done", 128'(fd_cnt), 128'd1);

        do_reset(1);
        for (int t = 0; t < 100 && acc_n < 13; t++) cyc3(1'b1, 1'b1);
        cyc3(1'b1, 1'b0);
        snap = s_win;
        check("bp_first_window", snap, exp_win(3, 5, 0));
        for (int t = 0; t < 4; t++) begin
            cyc3(1'b1, 1'b0);
            check("bp_window_stable", s_win, snap);
            check("bp_valid_held", s_ov, 1'b1);
            check("bp_in_ready_low", s_ir, 1'b0);
        end
        for (int t = 0; t < 100 && win_cnt < 9; t++) cyc3(1'b1, 1'b1);
        check("bp_windows", 128'(win_cnt), 128'd9);

        do_reset(1);
        for (int t = 0; t < 3000 && win_cnt < 27; t++)
            cyc3($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        check("rand_windows", 128'(win_cnt), 128'd27);
        check("rand_frame_done", 128'(fd_cnt), 128'd3);
        repeat (2) cyc3(1'b0, 1'b1);

        do_reset(1);
        for (int t = 0; t < 100 && acc_n < 14; t++) cyc3(1'b1, 1'b1);
        check("mid_valid_before_reset", ov3, 1'b1);
        do_reset(1);
        for (int t = 0; t < 100 && win_cnt < 9; t++) cyc3(1'b1, 1'b1);
        check("mid_windows", 128'(win_cnt), 128'd9);
        check("mid_frame_done", 128'(fd_cnt), 128'd1);

        repeat (2) @(posedge clk);
        #1;
        rs = 1'b0;
        @(negedge clk);
        check("k2_rst_valid", ov2, 1'b0);
        check("k4_rst_valid", ov4, 1'b0);
        @(posedge clk);
        #1;
        n2 = 0; n4 = 0; f2 = 0; f4 = 0;
        for (int p = 0; p < 20; p++) begin
            ivs = p < 16;
            pxs = 8'(p + 1);
            @(negedge clk);
            if (ov2) begin
                check("k2_window", p2, exp_win(2, 4, n2));
                n2++;
            end
            if (ov4) begin
                check("k4_window", p4, exp_win(4, 4, n4));
                n4++;
            end
            if (fd2) f2++;
            if (fd4) f4++;
            @(posedge clk);
            #1;
        end
        check("k2_windows", 128'(n2), 128'd6);
        check("k4_windows", 128'(n4), 128'd1);
        check("k2_frame_done", 128'(f2), 128'd1);
        check("k4_frame_done", 128'(f4), 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
